// File: rtl/processor_pkg.sv
// Shared constants for the 5-stage pipeline: datapath widths, bubble encoding
// and the jump opcodes recognised by fetch predecode.
package processor_pkg;

  localparam int unsigned PC_WIDTH   = 12;
  localparam int unsigned INSN_WIDTH = 32;
  localparam logic [INSN_WIDTH-1:0] NOP_INSN = 32'h0000_0000;

  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 27;
  localparam int unsigned OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

  localparam logic [OPCODE_W-1:0] OP_J   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_JAL = 5'b00011;

endpackage

// File: rtl/fd_pipe_reg.sv
// Generic pipeline latch with hold and flush; flush wins over hold so a squash
// always lands even while the hazard unit is stalling.
module fd_pipe_reg #(
  parameter int unsigned       WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] flush_d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (flush) begin
      q <= flush_d;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem address and
// fills the F/D register. Optional predecode of j/jal under FETCH_EARLY_JUMP_EN.
module fetch_stage
  import processor_pkg::*;
#(
  parameter int unsigned                  PC_WIDTH   = processor_pkg::PC_WIDTH,
  parameter int unsigned                  INSN_WIDTH = processor_pkg::INSN_WIDTH,
  parameter logic [PC_WIDTH-1:0]          RESET_PC   = '0,
  parameter logic [INSN_WIDTH-1:0]        NOP_INSN   = processor_pkg::NOP_INSN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  output logic [PC_WIDTH-1:0]   address_imem,
  input  logic [INSN_WIDTH-1:0] q_imem,
  output logic [INSN_WIDTH-1:0] fd_insn,
  output logic [PC_WIDTH-1:0]   fd_pc,
  output logic [PC_WIDTH-1:0]   fd_pc_plus1,
  output logic                  fd_valid,
  output logic                  fd_early_taken
);

  localparam int unsigned FD_W = INSN_WIDTH + 2 * PC_WIDTH + 2;
  localparam logic [FD_W-1:0] FD_RESET = {NOP_INSN, {PC_WIDTH{1'b0}}, {PC_WIDTH{1'b0}}, 2'b00};

  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] jump_target;
  logic                early_jump;
  logic [FD_W-1:0]     fd_d;
  logic [FD_W-1:0]     fd_flush_d;
  logic [FD_W-1:0]     fd_q;

  assign pc_plus1 = pc_q + PC_WIDTH'(1);

`ifdef FETCH_EARLY_JUMP_EN
  logic [OPCODE_W-1:0] opcode;
  assign opcode      = q_imem[OPCODE_HI:OPCODE_LO];
  assign early_jump  = valid_q && !stall && !redirect && (opcode == OP_J || opcode == OP_JAL);
  assign jump_target = q_imem[PC_WIDTH-1:0];
`else
  assign early_jump  = 1'b0;
  assign jump_target = pc_plus1;
`endif

  // Until the word at pc_q has actually been fetched (valid_q=0, right after
  // reset) the PC must not advance, otherwise RESET_PC would be skipped.
  always_comb begin
    next_pc = pc_q;
    if (reset) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      next_pc = redirect_target;
    end else if (stall) begin
      next_pc = pc_q;
    end else if (early_jump) begin
      next_pc = jump_target;
    end else if (valid_q) begin
      next_pc = pc_plus1;
    end
  end

  assign address_imem = next_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q <= next_pc;
      if (redirect || !stall) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign fd_d       = {(valid_q ? q_imem : NOP_INSN), pc_q, pc_plus1, valid_q, early_jump};
  assign fd_flush_d = {NOP_INSN, fd_pc, fd_pc_plus1, 2'b00};

  fd_pipe_reg #(
    .WIDTH       (FD_W),
    .RESET_VALUE (FD_RESET)
  ) u_fd_reg (
    .clock   (clock),
    .reset   (reset),
    .hold    (stall),
    .flush   (redirect),
    .d       (fd_d),
    .flush_d (fd_flush_d),
    .q       (fd_q)
  );

  assign {fd_insn, fd_pc, fd_pc_plus1, fd_valid, fd_early_taken} = fd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stall/redirect/reset against a transaction model.
module tb_fetch_stage;

  localparam logic [31:0] A = 32'h1111_0001;
  localparam logic [31:0] B = 32'h1111_0002;
  localparam logic [31:0] C = 32'h1111_0003;
  localparam logic [31:0] D = 32'h1111_0004;
  localparam logic [31:0] J_020 = 32'h0800_0020;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_target;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic [31:0] fd_insn;
  logic [11:0] fd_pc;
  logic [11:0] fd_pc_plus1;
  logic        fd_valid;
  logic        fd_early_taken;

  logic [31:0] imem [4096];

  int checks   = 0;
  int failures = 0;
  logic check_en = 1'b0;

  // Model: the fetch request whose data is on the imem output, and the F/D entry.
  logic [11:0] m_req_pc;
  logic        m_req_valid;
  logic [31:0] m_fd_insn;
  logic [11:0] m_fd_pc;
  logic [11:0] m_fd_pc_plus1;
  logic        m_fd_valid;
  logic        m_fd_early;

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .address_imem    (address_imem),
    .q_imem          (q_imem),
    .fd_insn         (fd_insn),
    .fd_pc           (fd_pc),
    .fd_pc_plus1     (fd_pc_plus1),
    .fd_valid        (fd_valid),
    .fd_early_taken  (fd_early_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) q_imem <= imem[address_imem];

  function automatic logic is_jump(input logic [31:0] w);
`ifdef FETCH_EARLY_JUMP_EN
    return (w[31:27] == 5'b00001) || (w[31:27] == 5'b00011);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] model_addr();
    logic [31:0] w;
    w = imem[m_req_pc];
    if (reset) return 12'd0;
    if (redirect) return redirect_target;
    if (stall) return m_req_pc;
    if (!m_req_valid) return m_req_pc;
    if (is_jump(w)) return w[11:0];
    return m_req_pc + 12'd1;
  endfunction

  always @(posedge clock or posedge reset) begin
    logic [11:0] nxt;
    if (reset) begin
      m_req_pc      = 12'd0;
      m_req_valid   = 1'b0;
      m_fd_insn     = 32'd0;
      m_fd_pc       = 12'd0;
      m_fd_pc_plus1 = 12'd0;
      m_fd_valid    = 1'b0;
      m_fd_early    = 1'b0;
    end else begin
      nxt = model_addr();
      if (redirect) begin
        m_fd_insn   = 32'd0;
        m_fd_valid  = 1'b0;
        m_fd_early  = 1'b0;
        m_req_pc    = nxt;
        m_req_valid = 1'b1;
      end else if (!stall) begin
        m_fd_insn     = m_req_valid ? imem[m_req_pc] : 32'd0;
        m_fd_pc       = m_req_pc;
        m_fd_pc_plus1 = m_req_pc + 12'd1;
        m_fd_valid    = m_req_valid;
        m_fd_early    = m_req_valid && is_jump(imem[m_req_pc]);
        m_req_pc      = nxt;
        m_req_valid   = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic rd, input logic [11:0] tgt);
    @(posedge clock);
    #2;
    reset           = rst;
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    #1;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_addr", {20'd0, address_imem}, {20'd0, model_addr()});
      checkOutput("model_fd_insn", fd_insn, m_fd_insn);
      checkOutput("model_fd_pc", {20'd0, fd_pc}, {20'd0, m_fd_pc});
      checkOutput("model_fd_pc_plus1", {20'd0, fd_pc_plus1}, {20'd0, m_fd_pc_plus1});
      checkOutput("model_fd_valid", {31'd0, fd_valid}, {31'd0, m_fd_valid});
      checkOutput("model_fd_early", {31'd0, fd_early_taken}, {31'd0, m_fd_early});
    end
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 12'd0;
    for (int i = 0; i < 4096; i++) imem[i] = $urandom;
    imem[0] = A; imem[1] = B; imem[2] = C; imem[3] = D;
    imem[4] = 32'h2000_0004; imem[5] = J_020; imem[6] = 32'h2000_0006; imem[7] = 32'h2000_0007;
    imem[12'h020] = 32'h2000_0020; imem[12'h021] = 32'h2000_0021;
    imem[12'h100] = 32'h2000_0100; imem[12'h101] = 32'h2000_0101;
    imem[12'hFFF] = 32'h2000_0FFF;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
    check_en = 1'b1;
    checkOutput("reset_fd_valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("reset_fd_insn", fd_insn, 32'd0);
    checkOutput("reset_fd_pc", {20'd0, fd_pc}, 32'd0);
    checkOutput("reset_addr", {20'd0, address_imem}, 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("start_addr", {20'd0, address_imem}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("first_edge_bubble", {31'd0, fd_valid}, 32'd0);
    checkOutput("first_edge_addr", {20'd0, address_imem}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("insn_a", fd_insn, A);
    checkOutput("insn_a_pc", {20'd0, fd_pc}, 32'd0);
    checkOutput("insn_a_valid", {31'd0, fd_valid}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);
    checkOutput("insn_b", fd_insn, B);
    checkOutput("insn_b_pc_plus1", {20'd0, fd_pc_plus1}, 32'd2);
    checkOutput("stall_addr", {20'd0, address_imem}, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);
    checkOutput("stall1_insn", fd_insn, B);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);
    checkOutput("stall2_pc", {20'd0, fd_pc}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("stall3_insn", fd_insn, B);
    checkOutput("release_addr", {20'd0, address_imem}, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h100);
    checkOutput("insn_c", fd_insn, C);
    checkOutput("redirect_addr", {20'd0, address_imem}, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("redirect_bubble", {31'd0, fd_valid}, 32'd0);
    checkOutput("redirect_bubble_insn", fd_insn, 32'd0);
    checkOutput("redirect_pc_hold", {20'd0, fd_pc}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("target_insn", fd_insn, 32'h2000_0100);
    checkOutput("target_pc", {20'd0, fd_pc}, 32'h100);

    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("wrap_addr", {20'd0, address_imem}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("wrap_fd_pc", {20'd0, fd_pc}, 32'hFFF);
    checkOutput("wrap_fd_pc_plus1", {20'd0, fd_pc_plus1}, 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b1, 12'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
`ifdef FETCH_EARLY_JUMP_EN
    checkOutput("jump_addr", {20'd0, address_imem}, 32'h020);
`else
    checkOutput("jump_addr", {20'd0, address_imem}, 32'd6);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("jump_fd_pc", {20'd0, fd_pc}, 32'd5);
`ifdef FETCH_EARLY_JUMP_EN
    checkOutput("jump_early_taken", {31'd0, fd_early_taken}, 32'd1);
`else
    checkOutput("jump_early_taken", {31'd0, fd_early_taken}, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("after_jump_valid", {31'd0, fd_valid}, 32'd1);
`ifdef FETCH_EARLY_JUMP_EN
    checkOutput("after_jump_pc", {20'd0, fd_pc}, 32'h020);
`else
    checkOutput("after_jump_pc", {20'd0, fd_pc}, 32'd6);
`endif

    #3 reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("async_reset_pc", {20'd0, fd_pc}, 32'd0);
    checkOutput("async_reset_insn", fd_insn, 32'd0);
    checkOutput("async_reset_addr", {20'd0, address_imem}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("restart_addr", {20'd0, address_imem}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("restart_fd_insn", fd_insn, A);
    checkOutput("restart_fd_valid", {31'd0, fd_valid}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 149) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0,
                    12'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    @(negedge clock);
    #1;
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
